// File: rtl/idct_block_writer_pkg.sv
// Shared constants and FSM encoding for the IDCT output block writer.
package idct_block_writer_pkg;

  localparam int IMG_W     = 64;
  localparam int IMG_H     = 64;
  localparam int DW        = 64;
  localparam int FRAC      = 24;
  localparam int PIX_W     = 12;
  localparam int ADDR_W    = 15;
  localparam int ADDR_BASE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/idct_block_writer_pixel_round_sat.sv
// Round-half-up of a signed fixed-point sample to an unsigned pixel, with
// clamping to [0, 2^PIX_W-1]. Purely combinational.
module pixel_round_sat #(
  parameter int DW    = 64,
  parameter int FRAC  = 24,
  parameter int PIX_W = 12
) (
  input  logic [DW-1:0]    i_data,
  output logic [PIX_W-1:0] o_pix,
  output logic             o_clip
);

  // One extra bit of headroom so adding the half-LSB can never wrap.
  localparam logic signed [DW:0] C_HALF = (DW+1)'(1) << (FRAC-1);
  localparam logic signed [DW:0] C_MAX  = {{(DW+1-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic signed [DW:0] w_sum;
  logic signed [DW:0] w_shr;

  assign w_sum = $signed({i_data[DW-1], i_data}) + C_HALF;
  assign w_shr = w_sum >>> FRAC;

  // Clamp the rounded value into the pixel range and flag any clip.
  always_comb begin
    o_pix  = w_shr[PIX_W-1:0];
    o_clip = 1'b0;
    if (w_shr[DW]) begin
      o_pix  = '0;
      o_clip = 1'b1;
    end else if (w_shr > C_MAX) begin
      o_pix  = {PIX_W{1'b1}};
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/idct_block_writer.sv
// Output end of the IDCT chain: rounds/saturates samples, transposes each 8x8
// block through a ping-pong buffer and writes it in the loader's stripe layout.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; no samples accepted
// ST_RUN  | frame in progress: filling and draining the two banks
// ST_DONE | one cycle after the last write of the frame (frame_done)
module idct_block_writer #(
  parameter int IMG_W     = idct_block_writer_pkg::IMG_W,
  parameter int IMG_H     = idct_block_writer_pkg::IMG_H,
  parameter int DW        = idct_block_writer_pkg::DW,
  parameter int FRAC      = idct_block_writer_pkg::FRAC,
  parameter int PIX_W     = idct_block_writer_pkg::PIX_W,
  parameter int ADDR_W    = idct_block_writer_pkg::ADDR_W,
  parameter int ADDR_BASE = idct_block_writer_pkg::ADDR_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [PIX_W-1:0]  dina,
  output logic              busy,
  output logic              frame_done,
  output logic              sat_flag
);

  import idct_block_writer_pkg::*;

  localparam int NB    = IMG_W * IMG_H / 64;
  localparam int BLK_W = (NB > 1) ? $clog2(NB) : 1;

  state_t r_state, w_state_nxt;

  logic [PIX_W-1:0]  r_bank [0:127];
  logic [1:0]        r_full;
  logic              r_wbank;
  logic              r_rbank;
  logic [5:0]        r_k;
  logic [5:0]        r_m;
  logic [BLK_W-1:0]  r_blk;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [PIX_W-1:0]  r_dina;
  logic              r_sat;
  logic              r_last;

  logic              w_start;
  logic              w_accept;
  logic              w_rd;
  logic [PIX_W-1:0]  w_pix;
  logic              w_clip;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic [6:0]        w_rd_idx;
  logic [ADDR_W-1:0] w_addr;

  pixel_round_sat #(
    .DW    (DW),
    .FRAC  (FRAC),
    .PIX_W (PIX_W)
  ) u_round (
    .i_data (in_data),
    .o_pix  (w_pix),
    .o_clip (w_clip)
  );

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_RUN) && in_valid && !r_full[r_wbank];
  assign w_rd     = (r_state == ST_RUN) && r_full[r_rbank];

  // Buffer is stored row-major; reading with row/col swapped gives the transpose.
  assign w_rd_idx = {r_rbank, r_m[2:0], r_m[5:3]};
  assign w_addr   = ADDR_W'(ADDR_BASE) + ADDR_W'({r_blk, r_m});

  // A bank is never set and cleared together, so the two masks can be merged freely.
  assign w_set = (w_accept && (r_k == 6'd63)) ? (2'b01 << r_wbank) : 2'b00;
  assign w_clr = (w_rd && (r_m == 6'd63))     ? (2'b01 << r_rbank) : 2'b00;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; r_last marks the cycle the final write is on the port.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (r_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ping-pong sample storage, written with already rounded pixels.
  always_ff @(posedge clk) begin
    if (w_accept) r_bank[{r_wbank, r_k}] <= w_pix;
  end

  // Fill/drain counters, bank pointers, full flags and sticky saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_m     <= '0;
      r_blk   <= '0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_full  <= '0;
      r_sat   <= 1'b0;
    end else if (w_start) begin
      r_k     <= '0;
      r_m     <= '0;
      r_blk   <= '0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_full  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_accept) begin
        r_k <= r_k + 6'd1;
        if (w_clip)        r_sat   <= 1'b1;
        if (r_k == 6'd63)  r_wbank <= ~r_wbank;
      end
      if (w_rd) begin
        r_m <= r_m + 6'd1;
        if (r_m == 6'd63) begin
          r_rbank <= ~r_rbank;
          r_blk   <= r_blk + 1'b1;
        end
      end
    end
  end

  // Registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_wea  <= w_rd;
      r_last <= w_rd && (r_m == 6'd63) && (r_blk == BLK_W'(NB - 1));
      if (w_rd) begin
        r_addra <= w_addr;
        r_dina  <= r_bank[w_rd_idx];
      end
    end
  end

  assign in_ready   = (r_state == ST_RUN) && !r_full[r_wbank];
  assign wea        = r_wea;
  assign addra      = r_addra;
  assign dina       = r_dina;
  assign busy       = (r_state == ST_RUN);
  assign frame_done = (r_state == ST_DONE);
  assign sat_flag   = r_sat;

endmodule

// File: tb/tb_idct_block_writer.sv
// Self-checking bench for idct_block_writer: a frame-level model predicts every
// write (address order, pixel value), in_ready, busy, frame_done and sat_flag.
module tb_idct_block_writer;

  localparam int PIX_W = 12;
  localparam int ADDR_W = 15;
  localparam int ABASE = 2;
  localparam int NPIX  = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [63:0]       in_data = '0;
  logic              in_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [PIX_W-1:0]  dina;
  logic              busy;
  logic              frame_done;
  logic              sat_flag;

  idct_block_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .busy       (busy),
    .frame_done (frame_done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit stuck = 0;

  // frame model
  int             phase = 0;
  int             n_acc = 0;
  int             n_wr = 0;
  bit             exp_sat = 0;
  logic [PIX_W-1:0] exp_pix [0:NPIX-1];
  logic [PIX_W-1:0] dut_mem [0:NPIX+ABASE-1];
  longint         cyc = 0;
  longint         last63_cyc = 0;
  longint         first_wea_cyc = 0;
  int             fd_pulses = 0;
  int             last_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Rounding rule: nearest integer (ties up), clamped to the pixel range.
  function automatic int model_pix(input logic [63:0] x, output bit clip);
    longint xs;
    real    r;
    longint v;
    xs = $signed(x);
    r  = $floor(real'(xs) / 16777216.0 + 0.5);
    v  = longint'(r);
    clip = 1'b0;
    if (v < 0) begin
      v = 0;
      clip = 1'b1;
    end else if (v > 4095) begin
      v = 4095;
      clip = 1'b1;
    end
    return int'(v);
  endfunction

  // Compare process: checks all outputs every cycle against the model.
  always @(negedge clk) begin
    int  idx, b, k, r, c, p;
    bit  clip;
    bit  exp_ready;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {wea, 15'(addra), 12'(dina), in_ready, busy, frame_done, sat_flag}, 64'd0);
      phase = 0; n_acc = 0; n_wr = 0; exp_sat = 0;
    end else begin
      chk("busy", busy, (phase == 1));
      chk("frame_done", frame_done, (phase == 2));
      chk("sat_flag", sat_flag, exp_sat);
      if (frame_done) fd_pulses++;
      if (wea) begin
        if (n_wr == 0) first_wea_cyc = cyc;
        chk("wr_in_run", (phase == 1), 1);
        chk("wr_addr", addra, ABASE + n_wr);
        chk("wr_block_complete", (n_acc >= (n_wr / 64 + 1) * 64), 1);
        if (n_wr < NPIX) chk("wr_data", dina, exp_pix[n_wr]);
        if (addra < ABASE + NPIX) dut_mem[addra] = dina;
        last_addr = addra;
        n_wr++;
      end
      exp_ready = (phase == 1) && ((n_acc / 64 - n_wr / 64) < 2);
      chk("in_ready", in_ready, exp_ready);
      if (in_valid && in_ready && n_acc < NPIX) begin
        idx = n_acc;
        b = idx / 64; k = idx % 64; r = k / 8; c = k % 8;
        p = model_pix(in_data, clip);
        exp_pix[b * 64 + c * 8 + r] = PIX_W'(p);
        if (clip) exp_sat = 1'b1;
        if (k == 63) last63_cyc = cyc;
        n_acc++;
      end
      if (phase == 2) phase = 0;
      else if (phase == 1 && n_wr == NPIX) phase = 2;
      else if (phase == 0 && start) begin
        phase = 1; n_acc = 0; n_wr = 0; exp_sat = 0;
        for (int i = 0; i < NPIX + ABASE; i++) dut_mem[i] = '1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    int n;
    if (stuck) return;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 2000) begin
        chk("send_timeout", 0, 1);
        stuck = 1;
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (n_wr < target && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("wait_writes", n_wr >= target, 1);
    repeat (4) @(posedge clk);
  endtask

  function automatic int img(input int x, input int y);
    return (x * 37 + y * 11 + 5) % 4096;
  endfunction

  initial begin
    int n;
    // 1: reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("t1_reset", {wea, 15'(addra), 12'(dina), in_ready, busy, frame_done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_idle_ready", in_ready, 0);

    // 2: single block, transpose and latency
    do_start();
    for (int k = 0; k < 64; k++) send(64'(k) << 24);
    in_valid = 1'b0;
    wait_wr(64);
    chk("t2_latency", first_wea_cyc - last63_cyc, 2);
    chk("t2_mem_r0c0", dut_mem[2], 0);
    chk("t2_mem_r0c1", dut_mem[10], 1);
    chk("t2_mem_r1c0", dut_mem[3], 8);
    chk("t2_mem_r2c5", dut_mem[44], 21);
    chk("t2_mem_r7c7", dut_mem[65], 63);
    chk("t2_write_count", n_wr, 64);

    // 3: rounding and saturation
    do_reset();
    do_start();
    send(64'h0000_0000_0080_0000);
    send(64'h0000_0000_007F_FFFF);
    send(64'(4095) << 24);
    chk("t3_sat_after_4095", sat_flag, 0);
    send(-64'sd16777216);
    chk("t3_sat_after_neg", sat_flag, 1);
    send(64'(5000) << 24);
    chk("t3_sat_after_5000", sat_flag, 1);
    for (int k = 5; k < 64; k++) send(64'd0);
    in_valid = 1'b0;
    wait_wr(64);
    chk("t3_half_up", dut_mem[2], 1);
    chk("t3_below_half", dut_mem[10], 0);
    chk("t3_max_exact", dut_mem[18], 4095);
    chk("t3_neg_clip", dut_mem[26], 0);
    chk("t3_pos_clip", dut_mem[34], 4095);

    // 4: three blocks back to back
    do_reset();
    do_start();
    for (int i = 0; i < 192; i++) send(64'((i * 7) % 4096) << 24);
    in_valid = 1'b0;
    wait_wr(192);
    chk("t4_write_count", n_wr, 192);
    chk("t4_last_addr", last_addr, 193);

    // 5: full frame with read-back in source layout
    do_reset();
    fd_pulses = 0;
    do_start();
    for (int by = 0; by < 8; by++)
      for (int bx = 0; bx < 8; bx++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            send(64'(img(bx * 8 + c, by * 8 + r)) << 24);
    in_valid = 1'b0;
    wait_wr(NPIX);
    chk("t5_last_addr", last_addr, 4097);
    chk("t5_done_pulses", fd_pulses, 1);
    chk("t5_busy_low", busy, 0);
    n = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        if (dut_mem[ABASE + (y / 8) * 512 + x * 8 + (y % 8)] !== PIX_W'(img(x, y))) n++;
    chk("t5_readback_errors", n, 0);

    // 6: reset mid-frame, then a clean restart
    do_reset();
    do_start();
    for (int i = 0; i < 3 * 64 + 31; i++) send(64'(i % 4096) << 24);
    in_valid = 1'b0;
    chk("t6_active_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {wea, 15'(addra), 12'(dina), in_ready, busy, frame_done, sat_flag}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start();
    for (int k = 0; k < 64; k++) send(64'(k + 100) << 24);
    in_valid = 1'b0;
    wait_wr(64);
    chk("t6_write_count", n_wr, 64);
    chk("t6_last_addr", last_addr, 65);
    chk("t6_first_pixel", dut_mem[2], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
